demux_rr_dispatch: RTL
======================

// Module: demux_rr_dispatch
// PURPOSE
//   Upstream sequencer for the 1-to-4 demux (demux1to4). Accepts words on a valid/ready input
//   and assigns each to one of 4 output channels in round-robin order, skipping disabled channels.
//   Drives the demux's d/sel pair and holds them stable until the selected channel accepts.
//   Also keeps a transfer count and raises a sticky error flag when no channel is enabled.
// PARAMETERS
//   WIDTH  1  data width of in_data/d; must match the downstream demux
//   CNT_W  8  width of the xfer_cnt transfer counter (wraps)
// PORTS
//   clk        in   1        clock; all state updates on the rising edge
//   rst        in   1        reset, asynchronous, active-high
//   in_valid   in   1        upstream word available
//   in_data    in   WIDTH    upstream word
//   in_ready   out  1        dispatcher can accept a word this cycle (combinational)
//   ch_en      in   4        per-channel enable mask; bit i enables channel i
//   ch_ready   in   4        per-channel accept; bit i = channel i takes d this cycle
//   d          out  WIDTH    data to the demux d input; 0 whenever out_valid=0
//   sel        out  2        channel select to the demux sel input
//   out_valid  out  1        d/sel hold a pending transfer
//   xfer_cnt   out  CNT_W    number of completed transfers, modulo 2^CNT_W
//   err_nochan out  1        sticky: set when in_valid=1 while ch_en=4'b0000
// BEHAVIOUR
//   - Reset (async, takes effect immediately):
//     state=IDLE, ptr=0, d=0, sel=0, out_valid=0, xfer_cnt=0, err_nochan=0.
//   - FSM states:
//     IDLE: no transfer pending.
//     HOLD: transfer pending; out_valid=1.
//   - in_ready = (state==IDLE) && (ch_en!=0).
//   - IDLE, on a clock edge with in_valid && in_ready:
//     d<=in_data; sel<=target; out_valid<=1; state<=HOLD.
//     target = first i in the cyclic order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with ch_en[i]=1.
//     Latency from input accept to out_valid is 1 cycle.
//   - HOLD:
//     d and sel stay stable; in_ready=0; ch_en changes are ignored for the pending word.
//     On an edge with ch_ready[sel]=1:
//       out_valid<=0; d<=0; ptr<=sel+1 (mod 4); xfer_cnt<=xfer_cnt+1 (wraps); state<=IDLE.
//     ch_ready bits of non-selected channels are ignored.
//   - Throughput: at most one word every 2 cycles (accept edge, then completion edge).
//   - sel keeps its last value in IDLE. d=0 in IDLE, so the demux drives all outputs 0.
//   - err_nochan: set on any edge with in_valid=1 && ch_en=0. Cleared only by rst.
//     in_ready=0 while ch_en=0; the word is not consumed.
//   - Simultaneous events:
//     ch_en goes to 0 during HOLD: the pending word still completes on its channel.
//     ch_en re-enabled in IDLE: the search restarts from the current ptr.
//   - Reset mid-HOLD: the pending word is dropped.
//     out_valid and d fall immediately; the next word targets channel 0 (if enabled).
//   - xfer_cnt wraps from 2^CNT_W-1 to 0 without error.
// TESTING
//   1. Reset: hold rst=1 -> d=0, sel=0, out_valid=0, xfer_cnt=0, err_nochan=0.
//      Release with ch_en=4'b1111 -> in_ready=1.
//   2. ch_en=1111, ch_ready=1111, four words d=1 back-to-back ->
//      sel 00,01,10,11 each with out_valid for 1 cycle; demux y0..y3 pulse in turn; xfer_cnt=4.
//   3. ch_en=4'b1010, three words -> sel sequence 01,11,01; channels 0 and 2 never selected.
//   4. Word targeted to sel=10 with ch_ready[2]=0 for 5 cycles ->
//      out_valid=1, sel=10, d stable, in_ready=0 for all 5 cycles.
//      Completes on the first edge with ch_ready[2]=1; next word goes to sel=11.
//   5. ch_en=0000, in_valid=1 -> in_ready=0, err_nochan=1 after the edge.
//      err_nochan stays 1 after ch_en=1111 until rst.
//   6. rst pulsed while in HOLD with sel=10 -> out_valid=0 and d=0 immediately (no clock edge).
//      Next word goes to sel=00. Also: with CNT_W=2, 5 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher feeding a 1-to-4 demux: takes one word at a time and
// holds it on d/sel until the chosen channel accepts it, skipping disabled channels.
module demux_rr_dispatch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       ch_en,
  input  logic [3:0]       ch_ready,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err_nochan,
  output logic             dbg_state
);

  // Handshake: a word moves on an edge where in_valid && in_ready; a pending
  // word moves on an edge where out_valid && ch_ready[sel]. Neither side may
  // withdraw a word it offers, and the dispatcher holds d/sel until taken.

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] target;
  logic [1:0] idx;
  logic       found;

  // First enabled channel in cyclic order starting at ptr.
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && ch_en[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE) && (ch_en != 4'b0000);
  assign dbg_state = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      d          <= '0;
      sel        <= 2'd0;
      out_valid  <= 1'b0;
      xfer_cnt   <= '0;
      err_nochan <= 1'b0;
    end else begin
      if (in_valid && (ch_en == 4'b0000)) begin
        err_nochan <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            d         <= in_data;
            sel       <= target;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // ch_en is deliberately not consulted here: the word finishes where it was sent.
          if (ch_ready[sel]) begin
            out_valid <= 1'b0;
            d         <= '0;
            ptr       <= sel + 2'd1;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
